y_stream_src: RTL and testbench

- Avalon-ST Video source that transmits complete frames into the Y-enhance pipeline's video sink (valid/ready/sop/eop, 24-bit beats).
- Each frame is a control packet followed by a video packet of synthetic test-pattern pixels.
- Configured over the same 4-bit-address slave register bus; used for bring-up and as the upstream driver in block-level benches.

---
 rtl/y_stream_src.sv | 271 +++++++++++++++++++++++++++
 tb/tb_y_stream_src.sv | 565 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y_stream_src.sv
// Avalon-ST Video test-pattern source: emits a control packet followed by a
// video packet per frame, configured through a small 4-bit-address register bus.
module y_stream_src #(
    parameter int DEFAULT_WIDTH  = 640,
    parameter int DEFAULT_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  slave_addr,
    input  logic        slave_rd,
    input  logic        slave_wr,
    input  logic [31:0] slave_wrdata,
    output logic [31:0] slave_rddata,
    output logic [23:0] video_out_data,
    output logic        video_out_valid,
    output logic        video_out_sop,
    output logic        video_out_eop,
    input  logic        video_out_ready,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        C_HDR = 3'd1,
        C_DAT = 3'd2,
        V_HDR = 3'd3,
        V_PIX = 3'd4
    } state_t;

    // Configuration registers (bus side)
    logic        go_q;
    logic [15:0] width_q;
    logic [15:0] height_q;
    logic [1:0]  mode_q;
    logic [7:0]  solid_q;
    logic [31:0] rddata_q;
    logic [31:0] rd_mux;

    // Frame engine state
    state_t      state_q, state_d;
    logic [1:0]  cbeat_q, cbeat_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic [15:0] sw_q, sw_d, sh_q, sh_d;
    logic [1:0]  smode_q, smode_d;
    logic [7:0]  ssolid_q, ssolid_d;
    logic        busy_q, busy_d;
    logic [31:0] frames_q, frames_d;
    logic        valid_q, valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic [23:0] data_q, data_d;
    logic        fdone_q, fdone_d;

    logic        xfer;
    logic        last_x;
    logic [15:0] x_nx, y_nx;
    logic [7:0]  pix_nx;
    logic [7:0]  pix_first;

    logic unused_wrdata;
    assign unused_wrdata = ^slave_wrdata[31:16];

    function automatic logic [7:0] pixel_f(input logic [1:0] mode, input logic [7:0] solid,
                                           input logic [15:0] x, input logic [15:0] y);
        logic [7:0] p;
        p = 8'h00;
        case (mode)
            2'd0: p = x[7:0];
            2'd1: p = y[7:0];
            2'd2: p = solid;
            2'd3: p = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            default: p = 8'h00;
        endcase
        return p;
    endfunction

    always_comb begin
        rd_mux = 32'd0;
        case (slave_addr)
            4'd0: rd_mux = {31'd0, go_q};
            4'd1: rd_mux = {16'd0, width_q};
            4'd2: rd_mux = {16'd0, height_q};
            4'd3: rd_mux = {16'd0, solid_q, 6'd0, mode_q};
            4'd4: rd_mux = frames_q;
            4'd5: rd_mux = {31'd0, busy_q};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            go_q     <= 1'b0;
            width_q  <= 16'(DEFAULT_WIDTH);
            height_q <= 16'(DEFAULT_HEIGHT);
            mode_q   <= 2'd0;
            solid_q  <= 8'd0;
            rddata_q <= 32'd0;
        end else begin
            if (slave_wr) begin
                case (slave_addr)
                    4'd0: go_q <= slave_wrdata[0];
                    4'd1: width_q <= slave_wrdata[15:0];
                    4'd2: height_q <= slave_wrdata[15:0];
                    4'd3: begin
                        mode_q  <= slave_wrdata[1:0];
                        solid_q <= slave_wrdata[15:8];
                    end
                    default: ;
                endcase
            end
            if (slave_rd) begin
                rddata_q <= rd_mux;
            end
        end
    end

    // Handshake: a beat moves when valid and ready are both high; while valid is
    // high and ready low every output register holds, and valid only drops after
    // the beat has moved.
    assign xfer      = valid_q & video_out_ready;
    assign last_x    = (x_q == sw_q - 16'd1);
    assign x_nx      = last_x ? 16'd0 : x_q + 16'd1;
    assign y_nx      = last_x ? y_q + 16'd1 : y_q;
    assign pix_nx    = pixel_f(smode_q, ssolid_q, x_nx, y_nx);
    assign pix_first = pixel_f(smode_q, ssolid_q, 16'd0, 16'd0);

    always_comb begin
        state_d  = state_q;
        cbeat_d  = cbeat_q;
        x_d      = x_q;
        y_d      = y_q;
        sw_d     = sw_q;
        sh_d     = sh_q;
        smode_d  = smode_q;
        ssolid_d = ssolid_q;
        busy_d   = busy_q;
        frames_d = frames_q;
        valid_d  = valid_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        data_d   = data_q;
        fdone_d  = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                sop_d   = 1'b0;
                eop_d   = 1'b0;
                if (go_q && (width_q != 16'd0) && (height_q != 16'd0)) begin
                    sw_d     = width_q;
                    sh_d     = height_q;
                    smode_d  = mode_q;
                    ssolid_d = solid_q;
                    busy_d   = 1'b1;
                    state_d  = C_HDR;
                    valid_d  = 1'b1;
                    sop_d    = 1'b1;
                    data_d   = 24'h00000F;
                end
            end
            C_HDR: begin
                if (xfer) begin
                    state_d = C_DAT;
                    cbeat_d = 2'd0;
                    sop_d   = 1'b0;
                    data_d  = {4'h0, sw_q[7:4], 4'h0, sw_q[11:8], 4'h0, sw_q[15:12]};
                end
            end
            C_DAT: begin
                if (xfer) begin
                    // cbeat_q names the control data beat currently on the bus
                    case (cbeat_q)
                        2'd0: begin
                            cbeat_d = 2'd1;
                            data_d  = {4'h0, sh_q[11:8], 4'h0, sh_q[15:12], 4'h0, sw_q[3:0]};
                        end
                        2'd1: begin
                            cbeat_d = 2'd2;
                            eop_d   = 1'b1;
                            data_d  = {8'h00, 4'h0, sh_q[3:0], 4'h0, sh_q[7:4]};
                        end
                        default: begin
                            state_d = V_HDR;
                            sop_d   = 1'b1;
                            eop_d   = 1'b0;
                            data_d  = 24'h000000;
                        end
                    endcase
                end
            end
            V_HDR: begin
                if (xfer) begin
                    state_d = V_PIX;
                    x_d     = 16'd0;
                    y_d     = 16'd0;
                    sop_d   = 1'b0;
                    eop_d   = (sw_q == 16'd1) && (sh_q == 16'd1);
                    data_d  = {pix_first, pix_first, pix_first};
                end
            end
            V_PIX: begin
                if (xfer) begin
                    if (eop_q) begin
                        state_d  = IDLE;
                        valid_d  = 1'b0;
                        eop_d    = 1'b0;
                        data_d   = 24'h000000;
                        busy_d   = 1'b0;
                        fdone_d  = 1'b1;
                        frames_d = frames_q + 32'd1;
                    end else begin
                        x_d    = x_nx;
                        y_d    = y_nx;
                        eop_d  = (x_nx == sw_q - 16'd1) && (y_nx == sh_q - 16'd1);
                        data_d = {pix_nx, pix_nx, pix_nx};
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                sop_d   = 1'b0;
                eop_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cbeat_q  <= 2'd0;
            x_q      <= 16'd0;
            y_q      <= 16'd0;
            sw_q     <= 16'd0;
            sh_q     <= 16'd0;
            smode_q  <= 2'd0;
            ssolid_q <= 8'd0;
            busy_q   <= 1'b0;
            frames_q <= 32'd0;
            valid_q  <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            data_q   <= 24'd0;
            fdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cbeat_q  <= cbeat_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sw_q     <= sw_d;
            sh_q     <= sh_d;
            smode_q  <= smode_d;
            ssolid_q <= ssolid_d;
            busy_q   <= busy_d;
            frames_q <= frames_d;
            valid_q  <= valid_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            data_q   <= data_d;
            fdone_q  <= fdone_d;
        end
    end

    assign slave_rddata    = rddata_q;
    assign video_out_data  = data_q;
    assign video_out_valid = valid_q;
    assign video_out_sop   = sop_q;
    assign video_out_eop   = eop_q;
    assign frame_done      = fdone_q;

endmodule

// File: tb/tb_y_stream_src.sv
// Bench for y_stream_src: frames are collected by a monitor and compared with a
// reference stream built directly from the packet and pattern rules.
module tb_y_stream_src;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  slave_addr;
    logic        slave_rd;
    logic        slave_wr;
    logic [31:0] slave_wrdata;
    logic [31:0] slave_rddata;
    logic [23:0] video_out_data;
    logic        video_out_valid;
    logic        video_out_sop;
    logic        video_out_eop;
    logic        video_out_ready = 1'b1;
    logic        frame_done;

    always #5 clk = ~clk;

    y_stream_src dut (
        .clk            (clk),
        .rst            (rst),
        .slave_addr     (slave_addr),
        .slave_rd       (slave_rd),
        .slave_wr       (slave_wr),
        .slave_wrdata   (slave_wrdata),
        .slave_rddata   (slave_rddata),
        .video_out_data (video_out_data),
        .video_out_valid(video_out_valid),
        .video_out_sop  (video_out_sop),
        .video_out_eop  (video_out_eop),
        .video_out_ready(video_out_ready),
        .frame_done     (frame_done)
    );

    // {sop, eop, data}
    logic [25:0] exp_q[$];
    logic [25:0] got_q[$];
    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int stall_viol = 0;
    int gap_viol = 0;
    int exp_frames = 0;
    bit ready_rand = 1'b0;
    logic ready_fixed = 1'b1;
    logic prev_stall = 1'b0;
    logic [25:0] prev_beat = '0;

    // Ready driver: new value shortly after each rising edge
    always @(posedge clk) begin
        #1;
        video_out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // Monitor samples mid-cycle, where inputs and outputs are settled for the next edge
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(video_out_valid &&
                {video_out_sop, video_out_eop, video_out_data} == prev_beat))
                stall_viol++;
            if (frame_done) begin
                fd_cnt++;
                if (video_out_valid) gap_viol++;
            end
            if (video_out_valid && video_out_ready)
                got_q.push_back({video_out_sop, video_out_eop, video_out_data});
            prev_stall = video_out_valid && !video_out_ready;
            prev_beat  = {video_out_sop, video_out_eop, video_out_data};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] ctl_word(input logic [3:0] s0, input logic [3:0] s1,
                                             input logic [3:0] s2);
        return {4'h0, s2, 4'h0, s1, 4'h0, s0};
    endfunction

    // Reference stream for one frame
    task automatic model_frame(input int w, input int h, input int mode, input logic [7:0] solid);
        logic [15:0] wv, hv;
        logic [7:0]  p;
        wv = 16'(w);
        hv = 16'(h);
        exp_q.push_back({2'b10, 24'h00000F});
        exp_q.push_back({2'b00, ctl_word(wv[15:12], wv[11:8], wv[7:4])});
        exp_q.push_back({2'b00, ctl_word(wv[3:0], hv[15:12], hv[11:8])});
        exp_q.push_back({2'b01, ctl_word(hv[7:4], hv[3:0], 4'h0)});
        exp_q.push_back({2'b10, 24'h000000});
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                logic [7:0] xb, yb;
                xb = 8'(x);
                yb = 8'(y);
                case (mode)
                    0: p = xb;
                    1: p = yb;
                    2: p = solid;
                    default: p = (xb[3] ^ yb[3]) ? 8'hFF : 8'h00;
                endcase
                exp_q.push_back({1'b0, (x == w - 1 && y == h - 1), p, p, p});
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
        slave_addr   = addr;
        slave_wrdata = data;
        slave_wr     = 1'b1;
        @(posedge clk);
        #1;
        slave_wr = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] addr, output logic [31:0] data);
        slave_addr = addr;
        slave_rd   = 1'b1;
        @(posedge clk);
        #1;
        slave_rd = 1'b0;
        data     = slave_rddata;
    endtask

    task automatic wait_fd(input int target, input string name);
        int cyc;
        cyc = 0;
        while (fd_cnt < target && cyc < 5000) begin
            tick(1);
            cyc++;
        end
        checks++;
        if (fd_cnt < target) begin
            errors++;
            $display("FAIL %s frame_done timeout: got %0d pulses, need %0d", name, fd_cnt, target);
        end
    endtask

    task automatic wait_beats(input int n, input string name);
        int cyc;
        cyc = 0;
        while (got_q.size() < n && cyc < 5000) begin
            tick(1);
            cyc++;
        end
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL %s beat timeout: got %0d beats, need %0d", name, got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_regs[6];
        exp_regs = '{32'd0, 32'd640, 32'd480, 32'd0, 32'd0, 32'd0};
        checks++;
        if ({video_out_valid, video_out_sop, video_out_eop, frame_done} !== 4'b0000 ||
            video_out_data !== 24'd0 || slave_rddata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v%b s%b e%b fd%b data %h rd %h, need all zero",
                     video_out_valid, video_out_sop, video_out_eop, frame_done,
                     video_out_data, slave_rddata);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(2);
        for (int a = 0; a < 6; a++) begin
            reg_read(4'(a), rd);
            checks++;
            if (rd !== exp_regs[a]) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h, need %h", a, rd, exp_regs[a]);
            end
        end
        reg_write(4'd7, 32'hFFFF_FFFF);
        reg_read(4'd7, rd);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL unmapped_reg: got %h, need 0", rd);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        int fd0;
        ready_rand = 1'b0;
        ready_fixed = 1'b1;
        reg_write(4'd1, 32'd4);
        reg_write(4'd2, 32'd2);
        reg_write(4'd3, 32'd0);
        got_q.delete();
        exp_q.delete();
        fd0 = fd_cnt;
        reg_write(4'd0, 32'd1);
        reg_write(4'd0, 32'd0);
        wait_fd(fd0 + 1, "basic");
        tick(10);
        model_frame(4, 2, 0, 8'h00);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d beats, need %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h, need %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (fd_cnt - fd0 !== 1) begin
            errors++;
            $display("FAIL basic_frame_done: got %0d pulses, need 1", fd_cnt - fd0);
        end
        exp_frames++;
        reg_read(4'd4, rd);
        checks++;
        if (rd !== 32'(exp_frames)) begin
            errors++;
            $display("FAIL basic_frames: got %0d, need %0d", rd, exp_frames);
        end
        reg_read(4'd5, rd);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL basic_busy: got %0d, need 0", rd);
        end
    endtask

    task automatic test_random_ready();
        logic [31:0] rd;
        int fd0;
        ready_rand = 1'b1;
        stall_viol = 0;
        got_q.delete();
        exp_q.delete();
        fd0 = fd_cnt;
        reg_write(4'd0, 32'd1);
        reg_write(4'd0, 32'd0);
        wait_fd(fd0 + 1, "rand_ready");
        tick(10);
        ready_rand = 1'b0;
        model_frame(4, 2, 0, 8'h00);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_ready_count: got %0d beats, need %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_ready_beat%0d: got %h, need %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stall_viol !== 0) begin
            errors++;
            $display("FAIL rand_ready_stall: got %0d unstable stall cycles, need 0", stall_viol);
        end
        exp_frames++;
        reg_read(4'd4, rd);
        checks++;
        if (rd !== 32'(exp_frames)) begin
            errors++;
            $display("FAIL rand_ready_frames: got %0d, need %0d", rd, exp_frames);
        end
    endtask

    task automatic test_go_clear();
        logic [31:0] rd;
        int fd0, w, h, mode;
        logic [7:0] solid;
        w = $urandom_range(3, 8);
        h = $urandom_range(2, 4);
        mode = $urandom_range(0, 3);
        solid = 8'($urandom_range(0, 255));
        ready_rand = 1'b0;
        reg_write(4'd1, 32'(w));
        reg_write(4'd2, 32'(h));
        reg_write(4'd3, {16'd0, solid, 6'd0, 2'(mode)});
        got_q.delete();
        exp_q.delete();
        fd0 = fd_cnt;
        reg_write(4'd0, 32'd1);
        wait_beats(7, "go_clear");
        reg_write(4'd0, 32'd0);
        wait_fd(fd0 + 1, "go_clear");
        tick(30);
        model_frame(w, h, mode, solid);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL go_clear_count: got %0d beats, need %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL go_clear_beat%0d: got %h, need %h", i, got_q[i], exp_q[i]);
            end
        end
        exp_frames++;
        reg_read(4'd4, rd);
        checks++;
        if (rd !== 32'(exp_frames)) begin
            errors++;
            $display("FAIL go_clear_frames: got %0d, need %0d", rd, exp_frames);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int fd0, w, h, mode;
        logic [7:0] solid;
        w = $urandom_range(1, 12);
        h = $urandom_range(1, 6);
        mode = $urandom_range(0, 3);
        solid = 8'($urandom_range(0, 255));
        reg_write(4'd1, 32'(w));
        reg_write(4'd2, 32'(h));
        reg_write(4'd3, {16'd0, solid, 6'd0, 2'(mode)});
        ready_rand = 1'b1;
        stall_viol = 0;
        gap_viol = 0;
        got_q.delete();
        exp_q.delete();
        fd0 = fd_cnt;
        reg_write(4'd0, 32'd1);
        wait_fd(fd0 + 2, "b2b");
        reg_write(4'd0, 32'd0);
        wait_fd(fd0 + 3, "b2b");
        tick(40);
        ready_rand = 1'b0;
        for (int f = 0; f < 3; f++) model_frame(w, h, mode, solid);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats, need %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_beat%0d: got %h, need %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (gap_viol !== 0 || stall_viol !== 0) begin
            errors++;
            $display("FAIL b2b_gap_stall: got gap %0d stall %0d violations, need 0 0",
                     gap_viol, stall_viol);
        end
        exp_frames += 3;
        reg_read(4'd4, rd);
        checks++;
        if (rd !== 32'(exp_frames)) begin
            errors++;
            $display("FAIL b2b_frames: got %0d, need %0d", rd, exp_frames);
        end
    endtask

    task automatic test_zero_height();
        logic [31:0] rd;
        int fd0;
        ready_rand = 1'b0;
        reg_write(4'd1, 32'd4);
        reg_write(4'd2, 32'd0);
        reg_write(4'd3, {16'd0, 8'h5A, 6'd0, 2'd2});
        got_q.delete();
        exp_q.delete();
        fd0 = fd_cnt;
        reg_write(4'd0, 32'd1);
        tick(20);
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL zero_h_beats: got %0d beats, need 0", got_q.size());
        end
        reg_read(4'd5, rd);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL zero_h_busy: got %0d, need 0", rd);
        end
        slave_addr   = 4'd2;
        slave_wrdata = 32'd1;
        slave_wr     = 1'b1;
        tick(1);
        slave_wr = 1'b0;
        checks++;
        if (video_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_h_early_valid: got %b, need 0", video_out_valid);
        end
        tick(1);
        checks++;
        if (video_out_valid !== 1'b1 || video_out_sop !== 1'b1) begin
            errors++;
            $display("FAIL zero_h_start: got valid %b sop %b, need 1 1", video_out_valid, video_out_sop);
        end
        reg_write(4'd0, 32'd0);
        wait_fd(fd0 + 1, "zero_h");
        tick(10);
        model_frame(4, 1, 2, 8'h5A);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL zero_h_count: got %0d beats, need %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL zero_h_beat%0d: got %h, need %h", i, got_q[i], exp_q[i]);
            end
        end
        exp_frames++;
    endtask

    task automatic test_width_midframe();
        int fd0;
        ready_rand = 1'b0;
        reg_write(4'd1, 32'd4);
        reg_write(4'd2, 32'd2);
        reg_write(4'd3, 32'd0);
        got_q.delete();
        exp_q.delete();
        fd0 = fd_cnt;
        reg_write(4'd0, 32'd1);
        wait_beats(6, "width_mid");
        reg_write(4'd1, 32'd8);
        wait_fd(fd0 + 1, "width_mid");
        reg_write(4'd0, 32'd0);
        wait_fd(fd0 + 2, "width_mid");
        tick(20);
        model_frame(4, 2, 0, 8'h00);
        model_frame(8, 2, 0, 8'h00);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL width_mid_count: got %0d beats, need %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL width_mid_beat%0d: got %h, need %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_q.size() > 15 && got_q[15] !== {2'b00, 24'h000008}) begin
            errors++;
            $display("FAIL width_mid_ctl: got %h, need 0000008", got_q[15]);
        end
        exp_frames += 2;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd;
        logic [31:0] exp_regs[6];
        int fd0;
        exp_regs = '{32'd0, 32'd640, 32'd480, 32'd0, 32'd0, 32'd0};
        ready_rand = 1'b0;
        reg_write(4'd1, 32'd4);
        reg_write(4'd2, 32'd4);
        reg_write(4'd3, 32'd1);
        got_q.delete();
        reg_write(4'd0, 32'd1);
        wait_beats(8, "rst_mid");
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({video_out_valid, video_out_sop, video_out_eop, frame_done} !== 4'b0000 ||
            video_out_data !== 24'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got v%b s%b e%b fd%b data %h, need all zero",
                     video_out_valid, video_out_sop, video_out_eop, frame_done, video_out_data);
        end
        tick(1);
        rst = 1'b1;
        got_q.delete();
        exp_frames = 0;
        tick(15);
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL rst_mid_no_sop: got %0d beats, need 0", got_q.size());
        end
        for (int a = 0; a < 6; a++) begin
            reg_read(4'(a), rd);
            checks++;
            if (rd !== exp_regs[a]) begin
                errors++;
                $display("FAIL rst_mid_reg%0d: got %h, need %h", a, rd, exp_regs[a]);
            end
        end
        reg_write(4'd1, 32'd2);
        reg_write(4'd2, 32'd1);
        got_q.delete();
        exp_q.delete();
        fd0 = fd_cnt;
        reg_write(4'd0, 32'd1);
        reg_write(4'd0, 32'd0);
        wait_fd(fd0 + 1, "rst_mid_restart");
        tick(10);
        model_frame(2, 1, 0, 8'h00);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rst_mid_count: got %0d beats, need %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rst_mid_beat%0d: got %h, need %h", i, got_q[i], exp_q[i]);
            end
        end
        exp_frames++;
        reg_read(4'd4, rd);
        checks++;
        if (rd !== 32'(exp_frames)) begin
            errors++;
            $display("FAIL rst_mid_frames: got %0d, need %0d", rd, exp_frames);
        end
    endtask

    initial begin
        rst          = 1'b0;
        slave_addr   = 4'd0;
        slave_rd     = 1'b0;
        slave_wr     = 1'b0;
        slave_wrdata = 32'd0;
        #12;
        test_reset();
        test_basic();
        test_random_ready();
        test_go_clear();
        test_back_to_back();
        test_zero_height();
        test_width_midframe();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
